// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch server.
//   fetch_state_t   : top-level FSM states
//   FETCH_HALT_WORD : default encoding recognised as an in-band HALT
//   FETCH_NOP       : canonical no-op encoding
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] FETCH_HALT_WORD = 32'h0000_007F;
  localparam logic [31:0] FETCH_NOP       = 32'h0000_0013;

endpackage

// File: rtl/imem_sp.sv
// imem_sp: DEPTH x XLEN instruction RAM, one write port and one synchronous
// read port.
//   clk, rst : clock; rst clears only the read-data register, never the array
//   we/waddr/wdata : write port
//   re/raddr       : read enable and index; rdata updates only when re=1
//   rdata          : registered read data, doubles as the fetch output word
module imem_sp
  import fetch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Holding rdata when re=0 is what keeps the presented instruction stable
  // across stalls, bubbles and the terminal states.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fetch_server.sv
// fetch_server: run-time loadable instruction RAM with a registered fetch
// stage presenting {instruction, PC, nextPC} through a valid/ready handshake.
//   clk, rst            : clock, synchronous active-high reset
//   start, hlt          : leave IDLE / external halt request
//   jump, next          : redirect fetch to absolute word address next
//   out_ready           : downstream accepts the presented instruction
//   load_en/addr/data   : RAM write port, honoured only in IDLE
//   instruction, PC, nextPC, instr_valid : presented fetch result
//   halted, fault       : state is HALTED / FAULT
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | RAM loadable, nothing presented, waiting for start
// RUN    | fetching one word per advance, jump/halt/fault evaluated
// HALTED | stopped by hlt or accepted HALT_WORD; outputs frozen until rst
// FAULT  | fetch address fell outside the RAM; sticky until rst
module fetch_server
  import fetch_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 64,
  parameter int unsigned     RESET_PC    = 0,
  parameter logic [XLEN-1:0] HALT_WORD   = XLEN'(FETCH_HALT_WORD),
  parameter bit              HALT_DETECT = 1'b1,
  localparam int             AW          = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            hlt,
  input  logic            jump,
  input  logic [XLEN-1:0] next,
  input  logic            out_ready,
  input  logic            load_en,
  input  logic [AW-1:0]   load_addr,
  input  logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] instruction,
  output logic            instr_valid,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] nextPC,
  output logic            halted,
  output logic            fault
);

  localparam logic [XLEN-1:0] PC_INIT   = XLEN'(RESET_PC);
  localparam logic [XLEN-1:0] DEPTH_LIM = XLEN'(DEPTH);
  localparam logic [XLEN-1:0] ONE       = XLEN'(1);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc;

  logic advance;
  logic out_of_range;
  logic halt_seen;
  logic rd_en;
  logic wr_en;
  logic redirect;
  logic drop_valid;

  assign advance      = !instr_valid || out_ready;
  // Full-width compare so a jump far past the RAM can never alias back in.
  assign out_of_range = (fetch_pc >= DEPTH_LIM);
  assign halt_seen    = HALT_DETECT && instr_valid && out_ready
                        && (instruction == HALT_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority inside RUN: fault > halt > jump > advance.
  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    redirect   = 1'b0;
    drop_valid = 1'b0;
    case (state_q)
      IDLE: begin
        wr_en = load_en;
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (advance && out_of_range) begin
          state_d    = FAULT;
          drop_valid = 1'b1;
        end else if (hlt || halt_seen) begin
          state_d    = HALTED;
          drop_valid = 1'b1;
        end else if (jump) begin
          redirect = 1'b1;
        end else if (advance) begin
          rd_en = 1'b1;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // A redirect clears valid and skips the read, which kills the in-flight
  // word and leaves exactly one bubble before the target is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= PC_INIT;
      PC          <= PC_INIT;
      nextPC      <= PC_INIT + ONE;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      fetch_pc    <= next;
      instr_valid <= 1'b0;
    end else if (rd_en) begin
      fetch_pc    <= fetch_pc + ONE;
      PC          <= fetch_pc;
      nextPC      <= fetch_pc + ONE;
      instr_valid <= 1'b1;
    end else if (drop_valid) begin
      instr_valid <= 1'b0;
    end
  end

  imem_sp #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_imem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (rd_en),
    .raddr (fetch_pc[AW-1:0]),
    .rdata (instruction)
  );

  assign halted = (state_q == HALTED);
  assign fault  = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_server.sv
// tb_fetch_server: directed scenarios plus a randomized jump/stall run,
// checked against a RAM image and an expected-address scoreboard.
module tb_fetch_server;
  import fetch_pkg::*;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst, start, hlt, jump, out_ready, load_en;
  logic [31:0] next, load_data;
  logic [5:0]  load_addr;
  logic [31:0] instruction, PC, nextPC;
  logic        instr_valid, halted, fault;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] exp_pc;
  logic [31:0] w;
  logic        prev_jump;

  always #5 clk = ~clk;

  fetch_server #(
    .XLEN        (32),
    .DEPTH       (DEPTH),
    .RESET_PC    (0),
    .HALT_WORD   (FETCH_HALT_WORD),
    .HALT_DETECT (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .hlt         (hlt),
    .jump        (jump),
    .next        (next),
    .out_ready   (out_ready),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .PC          (PC),
    .nextPC      (nextPC),
    .halted      (halted),
    .fault       (fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    start = 1'b0; hlt = 1'b0; jump = 1'b0; next = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
  endtask

  // Reset, then start: returns one cycle after entering RUN, nothing presented yet.
  task automatic restart();
    quiet();
    rst = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    quiet();
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // reset state
    chk("rst_pc", PC, 32'd0);
    chk("rst_npc", nextPC, 32'd1);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);

    // fill RAM with random non-HALT words, then the fixed program
    for (int a = 0; a < DEPTH; a++) begin
      w = $urandom;
      if (w == FETCH_HALT_WORD) w = FETCH_NOP;
      load_en = 1'b1; load_addr = 6'(a); load_data = w; mdl[a] = w;
      step();
    end
    mdl[0] = 32'h0060_0513; mdl[1] = 32'h0140_00EF; mdl[2] = 32'h0000_0013;
    for (int a = 0; a < 3; a++) begin
      load_en = 1'b1; load_addr = 6'(a); load_data = mdl[a];
      step();
    end
    load_en = 1'b0;

    // 1: straight-line fetch
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("seq_pc", PC, 32'(i));
      chk("seq_npc", nextPC, 32'(i + 1));
      chk("seq_instr", instruction, mdl[i]);
      chk("seq_valid", {31'b0, instr_valid}, 32'd1);
    end

    // 2: stall while PC=1 is presented
    restart();
    out_ready = 1'b1;
    step();
    step();
    chk("stall_pre_pc", PC, 32'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", PC, 32'd1);
      chk("stall_instr", instruction, 32'h0140_00EF);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk("stall_rel_pc", PC, 32'd2);
    chk("stall_rel_instr", instruction, 32'h0000_0013);

    // 3: jump to 6 while PC=1 is presented
    restart();
    step();
    step();
    jump = 1'b1; next = 32'd6;
    step();
    jump = 1'b0;
    chk("jmp_bubble", {31'b0, instr_valid}, 32'd0);
    step();
    chk("jmp_pc", PC, 32'd6);
    chk("jmp_npc", nextPC, 32'd7);
    chk("jmp_instr", instruction, mdl[6]);
    chk("jmp_valid", {31'b0, instr_valid}, 32'd1);

    // randomized stall/jump run against the expected-address scoreboard
    restart();
    out_ready = 1'b1;
    step();
    exp_pc = 32'd0;
    prev_jump = 1'b0;
    for (int i = 0; i < 400; i++) begin
      chk("rnd_valid", {31'b0, instr_valid}, {31'b0, !prev_jump});
      if (instr_valid) begin
        chk("rnd_pc", PC, exp_pc);
        chk("rnd_npc", nextPC, exp_pc + 32'd1);
        chk("rnd_instr", instruction, mdl[exp_pc[5:0]]);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      jump = 1'b0;
      prev_jump = 1'b0;
      if ((instr_valid && exp_pc >= 32'd48) || $urandom_range(0, 19) == 0) begin
        jump = 1'b1;
        next = 32'($urandom_range(0, 40));
        prev_jump = 1'b1;
        exp_pc = next;
      end else if (instr_valid && out_ready) begin
        exp_pc = exp_pc + 32'd1;
      end
      step();
    end
    jump = 1'b0;
    out_ready = 1'b1;

    // 4: in-band HALT at RAM[5]; RAM[0] written in the same cycle as start
    quiet();
    rst = 1'b1;
    step();
    rst = 1'b0;
    load_en = 1'b1; load_addr = 6'd5; load_data = FETCH_HALT_WORD; mdl[5] = FETCH_HALT_WORD;
    step();
    w = $urandom;
    if (w == FETCH_HALT_WORD) w = FETCH_NOP;
    load_addr = 6'd0; load_data = w; mdl[0] = w; start = 1'b1;
    step();
    load_en = 1'b0; start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("hw_pc", PC, 32'(i));
      chk("hw_instr", instruction, mdl[i]);
    end
    step();
    chk("hw_halted", {31'b0, halted}, 32'd1);
    chk("hw_valid", {31'b0, instr_valid}, 32'd0);
    chk("hw_pc_frz", PC, 32'd5);
    chk("hw_npc_frz", nextPC, 32'd6);
    jump = 1'b1; next = 32'd10; start = 1'b1;
    step();
    step();
    jump = 1'b0; start = 1'b0;
    chk("hw_term_pc", PC, 32'd5);
    chk("hw_term_halted", {31'b0, halted}, 32'd1);
    chk("hw_term_valid", {31'b0, instr_valid}, 32'd0);

    // 5: jump past the RAM faults
    restart();
    step();
    jump = 1'b1; next = 32'd64;
    step();
    jump = 1'b0;
    chk("flt_bubble", {31'b0, instr_valid}, 32'd0);
    chk("flt_not_yet", {31'b0, fault}, 32'd0);
    step();
    chk("flt_fault", {31'b0, fault}, 32'd1);
    chk("flt_valid", {31'b0, instr_valid}, 32'd0);
    chk("flt_pc", PC, 32'd0);
    start = 1'b1;
    step();
    step();
    step();
    start = 1'b0;
    chk("flt_sticky", {31'b0, fault}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("flt_rst_fault", {31'b0, fault}, 32'd0);
    chk("flt_rst_pc", PC, 32'd0);
    chk("flt_rst_npc", nextPC, 32'd1);
    step();
    step();
    chk("flt_idle_valid", {31'b0, instr_valid}, 32'd0);

    // 6: load_en in RUN with simultaneous jump and hlt
    restart();
    step();
    load_en = 1'b1; load_addr = 6'd20; load_data = ~mdl[20];
    jump = 1'b1; next = 32'd30; hlt = 1'b1;
    step();
    quiet();
    chk("mix_halted", {31'b0, halted}, 32'd1);
    chk("mix_valid", {31'b0, instr_valid}, 32'd0);
    chk("mix_pc", PC, 32'd0);
    step();
    chk("mix_pc_hold", PC, 32'd0);
    restart();
    jump = 1'b1; next = 32'd20;
    step();
    jump = 1'b0;
    step();
    chk("mix_rb_pc", PC, 32'd20);
    chk("mix_rb_instr", instruction, mdl[20]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
